// File: rtl/alu_lane_sequencer.sv
`timescale 1ns/1ps
// Runs a LANES x LANE_W vector op (or a single scalar pass) through one shared lane ALU, low lane first.
// Vector: done 5 cycles after accept, scalar: 2; stall_o holds upstream while RUN; flush_i aborts.
module alu_lane_sequencer #(
    parameter int LANE_W = 32,
    parameter int LANES  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     vf_i,
    input  logic [2:0]               op_i,
    input  logic [LANE_W*LANES-1:0]  opa_i,
    input  logic [LANE_W*LANES-1:0]  opb_i,
    input  logic                     flush_i,
    output logic [LANE_W-1:0]        lane_a_o,
    output logic [LANE_W-1:0]        lane_b_o,
    output logic [2:0]               lane_op_o,
    input  logic [LANE_W-1:0]        lane_res_i,
    output logic [LANE_W*LANES-1:0]  result_o,
    output logic                     busy_o,
    output logic                     stall_o,
    output logic                     done_o
);

    localparam int VEC_W = LANE_W * LANES;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   lane_q, lane_d;
    logic [VEC_W-1:0]   a_q, a_d;
    logic [VEC_W-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               vf_q, vf_d;
    logic [VEC_W-1:0]   result_q, result_d;
    logic               last_pass;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            vf_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            vf_q     <= vf_d;
            result_q <= result_d;
        end
    end

    assign last_pass = vf_q ? (lane_q == IDX_W'(LANES - 1)) : 1'b1;

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        vf_d     = vf_q;
        result_d = result_q;
        case (state_q)
            RUN: begin
                // The lane being processed this cycle is kept even when flushed here.
                if (vf_q) begin
                    result_d[LANE_W*lane_q +: LANE_W] = lane_res_i;
                end else begin
                    result_d               = '0;
                    result_d[LANE_W-1:0]   = lane_res_i;
                end
                if (flush_i) begin
                    state_d = IDLE;
                end else if (last_pass) begin
                    state_d = DONE;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i && !flush_i) begin
                    state_d = RUN;
                    lane_d  = '0;
                    a_d     = opa_i;
                    b_d     = opb_i;
                    op_d    = op_i;
                    vf_d    = vf_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lane_a_o  = (state_q == RUN) ? a_q[LANE_W*lane_q +: LANE_W] : '0;
    assign lane_b_o  = (state_q == RUN) ? b_q[LANE_W*lane_q +: LANE_W] : '0;
    assign lane_op_o = op_q;
    assign result_o  = result_q;
    assign busy_o    = (state_q == RUN);
    assign stall_o   = (state_q == RUN);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_alu_lane_sequencer.sv
`timescale 1ns/1ps
// Directed bench for alu_lane_sequencer with an adding lane ALU model.
module tb_alu_lane_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         vf;
    logic [2:0]   op;
    logic [127:0] opa;
    logic [127:0] opb;
    logic         flush;
    logic [31:0]  lane_a;
    logic [31:0]  lane_b;
    logic [2:0]   lane_op;
    logic [31:0]  lane_res;
    logic [127:0] result;
    logic         busy;
    logic         stall;
    logic         done;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;

    localparam logic [127:0] VEC1_A = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] VEC1_B = 128'h00000010_00000010_00000010_00000010;
    localparam logic [127:0] VEC1_R = 128'h00000014_00000013_00000012_00000011;
    localparam logic [127:0] VEC2_A = 128'h00000040_00000030_00000020_00000010;
    localparam logic [127:0] VEC2_B = 128'h00000001_00000001_00000001_00000001;
    localparam logic [127:0] VEC2_R = 128'h00000041_00000031_00000021_00000011;
    localparam logic [127:0] FLB    = 128'h00000100_00000100_00000100_00000100;
    localparam logic [127:0] FLR    = 128'h00000041_00000031_00000102_00000101;

    always #5 clk = ~clk;

    assign lane_res = lane_a + lane_b;

    always @(posedge clk) if (done === 1'b1) n_done++;

    alu_lane_sequencer #(.LANE_W(32), .LANES(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .vf_i       (vf),
        .op_i       (op),
        .opa_i      (opa),
        .opb_i      (opb),
        .flush_i    (flush),
        .lane_a_o   (lane_a),
        .lane_b_o   (lane_b),
        .lane_op_o  (lane_op),
        .lane_res_i (lane_res),
        .result_o   (result),
        .busy_o     (busy),
        .stall_o    (stall),
        .done_o     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; vf = 1'b1; op = 3'd0;
        opa = VEC1_A; opb = VEC1_B; flush = 1'b0;

        // Reset held two edges with start asserted
        repeat (2) tick();
        check("rst_result", result, '0);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_stall", 128'(stall), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_lane_a", 128'(lane_a), 128'(0));
        check("rst_lane_op", 128'(lane_op), 128'(0));
        rst = 1'b1; start = 1'b0;
        tick();
        check("idle_busy", 128'(busy), 128'(0));

        // Vector add: lanes 1..4 over cycles 1..4, done in cycle 5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("vec_lane_a%0d", i), 128'(lane_a), 128'(i + 1));
            check($sformatf("vec_stall%0d", i), 128'(stall), 128'(1));
            tick();
        end
        check("vec_lane_b_idle", 128'(lane_b), 128'(0));
        check("vec_done", 128'(done), 128'(1));
        check("vec_stall_done", 128'(stall), 128'(0));
        check("vec_result", result, VEC1_R);
        tick();
        check("vec_done_after", 128'(done), 128'(0));
        check("vec_result_hold", result, VEC1_R);
        check("vec_ndone", 128'(n_done), 128'(1));

        // Scalar add with dirty upper bits, op=3 passed through
        vf = 1'b0; op = 3'd3;
        opa = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'd7};
        opb = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'd5};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sc_busy", 128'(busy), 128'(1));
        check("sc_lane_a", 128'(lane_a), 128'(7));
        check("sc_lane_op", 128'(lane_op), 128'(3));
        tick();
        check("sc_done", 128'(done), 128'(1));
        check("sc_result", result, 128'h0C);
        tick();
        check("sc_idle", 128'(busy | done), 128'(0));
        check("sc_lane_op_hold", 128'(lane_op), 128'(3));
        check("sc_ndone", 128'(n_done), 128'(2));

        // Back-to-back with a start pulse ignored during RUN
        vf = 1'b1; op = 3'd0; opa = VEC1_A; opb = VEC1_B;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; opa = VEC2_A; opb = VEC2_B;
        tick();
        start = 1'b0; opa = VEC1_A; opb = VEC1_B;
        tick();
        check("b2b_lane3", 128'(lane_a), 128'(4));
        tick();
        check("b2b_done1", 128'(done), 128'(1));
        check("b2b_result1", result, VEC1_R);
        start = 1'b1; opa = VEC2_A; opb = VEC2_B;
        tick();
        start = 1'b0;
        check("b2b_run_nogap", 128'(stall), 128'(1));
        check("b2b_lane0", 128'(lane_a), 128'(32'h10));
        repeat (3) tick();
        tick();
        check("b2b_done2", 128'(done), 128'(1));
        check("b2b_result2", result, VEC2_R);
        tick();
        check("b2b_ndone", 128'(n_done), 128'(4));

        // Flush in cycle 2 of a vector op
        opa = VEC1_A; opb = FLB;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_idle", 128'(busy | stall | done), 128'(0));
        check("fl_result", result, FLR);
        repeat (4) tick();
        check("fl_ndone", 128'(n_done), 128'(4));
        check("fl_result_hold", result, FLR);

        // flush together with start in IDLE
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        check("flst_idle", 128'(busy), 128'(0));
        tick();
        check("flst_idle2", 128'(busy | done), 128'(0));

        // Reset in cycle 3 of a vector op, then a clean run
        opa = VEC1_A; opb = VEC1_B;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rr_busy", 128'(busy), 128'(0));
        check("rr_result", result, '0);
        check("rr_lane_op", 128'(lane_op), 128'(0));
        tick();
        check("rr_nodone", 128'(done), 128'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("rr_done", 128'(done), 128'(1));
        check("rr_result2", result, VEC1_R);
        tick();
        check("rr_ndone", 128'(n_done), 128'(5));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_lane_sequencer.md
Name: alu_lane_sequencer

Overview:
Multi-cycle sequencer that runs a 128-bit vector operation through one shared 32-bit lane ALU, one lane per cycle, low lane first. It sits beside the execute stage. It latches the operands, drives the lane ALU, collects the lane results into a 128-bit result, and holds the pipeline with a stall signal until the result is ready. Scalar operations take a single pass. A branch flush can abort the operation.

Parameters:
LANE_W, 32, width of one lane and of the shared lane ALU
LANES, 4, lanes per vector; vector width is LANE_W*LANES (128)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  request to begin an operation
vf  input  1  1 = vector op (LANES passes), 0 = scalar op (1 pass)
op  input  3  ALU instruction code, passed through to the lane ALU
opa  input  LANE_W*LANES  operand A (R2/V2 after forwarding)
opb  input  LANE_W*LANES  operand B (R3/V3 after forwarding)
flush  input  1  abort, driven from the branch-taken signal
lane_a  output  LANE_W  lane ALU operand A
lane_b  output  LANE_W  lane ALU operand B
lane_op  output  3  lane ALU instruction
lane_res  input  LANE_W  lane ALU result (combinational, same cycle)
result  output  LANE_W*LANES  assembled result register
busy  output  1  operation in progress
stall  output  1  hold upstream pipeline registers
done  output  1  one-cycle pulse: result valid

Behaviour:
- Reset (rst=0 at an edge) puts the state in IDLE and clears everything: result=0, busy=0, stall=0, done=0, lane index=0, latched operands and op=0. lane_a, lane_b and lane_op therefore read 0.
- States:
  - IDLE: waiting for work.
  - RUN: one lane is processed per cycle.
  - DONE: the result is valid for exactly one cycle.
- Start acceptance: a start is accepted at an edge where state is IDLE or DONE, start=1 and flush=0.
  - On acceptance, latch opa, opb, op and vf, set the lane index to 0 and go to RUN.
  - start is ignored while in RUN.
  - An accept from DONE gives back-to-back operation with no idle cycle.
- RUN cycle, with lane index i:
  - lane_a = latched A[LANE_W*i +: LANE_W], lane_b = latched B[LANE_W*i +: LANE_W], lane_op = latched op.
  - At the edge:
    - vector op: result[LANE_W*i +: LANE_W] <= lane_res.
    - scalar op: result <= {zeros, lane_res}, upper 96 bits zero.
  - Last pass (i==LANES-1 for vector, i==0 for scalar): go to DONE; otherwise i <= i+1.
- Outside RUN, lane_a and lane_b are 0 and lane_op holds the latched op.
- Latency: the accept edge is cycle 0.
  - Vector: RUN during cycles 1..4, done=1 in cycle 5.
  - Scalar: RUN during cycle 1, done=1 in cycle 2.
- Status outputs:
  - done is 1 only in DONE.
  - busy is 1 in RUN.
  - stall is combinational and equals (state==RUN).
- result holds its value after DONE until the next operation writes its first lane.
- Flush:
  - flush=1 at an edge while in RUN: go to IDLE, no done pulse. Lanes already written stay in result; the remaining lanes are not written.
  - flush=1 in DONE: go to IDLE.
  - flush takes priority over start at the same edge; that start is dropped.
- Reset in the middle of an operation: IDLE with all values cleared at that edge, and no done pulse.
- The lane index is a clog2(LANES)-bit counter. It never wraps within an operation and is cleared on every accept.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> result=0, busy=0, stall=0, done=0, lane_a=0.
- Vector op: opa=128'h00000004_00000003_00000002_00000001, opb=all lanes 32'h10, op=3'd0, vf=1. Lane ALU model adds. -> lane_a sequence is 1,2,3,4 over cycles 1..4; stall=1 in cycles 1..4; done in cycle 5; result=128'h00000014_00000013_00000012_00000011.
- Scalar op: opa[31:0]=7, opb[31:0]=5, upper bits 0xFF.., vf=0, add model -> one RUN cycle; done in cycle 2; result=128'h0...0C, upper 96 bits zero.
- Back-to-back: assert a second start (vf=1) during the DONE cycle of the first -> RUN the next cycle, no IDLE gap. A start pulsed during RUN is ignored (exactly one done per accepted start).
- Flush in the middle of a vector op: flush=1 in cycle 2 -> IDLE in cycle 3, no done. result lanes 0–1 are updated and lanes 2–3 keep their old values. flush and start together in IDLE -> stays IDLE.
- Reset during RUN: rst=0 in cycle 3 -> next cycle IDLE, result=0, no done; a new start then runs to completion normally.
